// File: rtl/from_diagonal_stream_if.sv
// Handshake bundle for from_diagonal_stream.
// A matrix is offered on the "in" side. Diagonal elements come back one per
// beat on the "out" side. The "slave" modport is the block's view and the
// "master" modport is the view of the producer/consumer.
interface from_diagonal_stream_if #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
);
    localparam int N  = (ROWS < COLS) ? ROWS : COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in [ROWS][COLS];
    logic                 out_valid;
    logic                 out_ready;
    logic [BIT_WIDTH-1:0] out;
    logic [IW-1:0]        out_index;
    logic                 out_last;
    logic                 is_diagonal;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, out_index, out_last, is_diagonal
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, out_index, out_last, is_diagonal
    );
endinterface

// File: rtl/from_diagonal_stream.sv
// from_diagonal_stream: accepts a ROWS x COLS matrix in a single handshake.
// It then streams the N = min(ROWS, COLS) diagonal elements one beat at a
// time, with a valid/ready handshake on the output side.
// Optional feature: when FROM_DIAGONAL_STREAM_CHECK_EN is defined, is_diagonal
// reports whether every off-diagonal element of the captured matrix was zero.
// Without that macro, is_diagonal is tied to 0 and no comparison logic is built.
module from_diagonal_stream #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    from_diagonal_stream_if.slave   bus
);
    localparam int N  = (ROWS < COLS) ? ROWS : COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state_reg;
    logic [IW-1:0]        k_reg;
    logic [IW-1:0]        k_next;
    logic [BIT_WIDTH-1:0] out_reg;
    logic                 out_last_reg;
    logic [BIT_WIDTH-1:0] diag_reg [N];
    logic [BIT_WIDTH-1:0] diag_in  [N];
    logic                 accept;
    logic                 advance;
    logic                 at_last;

    genvar gi;

    // Only the leading square's diagonal is captured; extra rows/cols are dropped.
    generate
        for (gi = 0; gi < N; gi++) begin : g_diag
            assign diag_in[gi] = bus.in[gi][gi];
        end
    endgenerate

    assign accept  = bus.in_valid && (state_reg == IDLE);
    assign advance = bus.out_ready && (state_reg == STREAM);
    assign at_last = (k_reg == IW'(N - 1));
    assign k_next  = k_reg + 1'b1;

    // Diagonal storage: plain data, loaded only on an accepted matrix.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            diag_reg <= diag_in;
        end
    end

    // Control FSM plus registered beat outputs (element, index, last flag).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            out_reg      <= '0;
            out_last_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg    <= STREAM;
                        k_reg        <= '0;
                        out_reg      <= diag_in[0];
                        out_last_reg <= (N == 1);
                    end
                end
                STREAM: begin
                    if (advance) begin
                        if (at_last) begin
                            state_reg    <= IDLE;
                            k_reg        <= '0;
                            out_last_reg <= 1'b0;
                        end else begin
                            k_reg        <= k_next;
                            out_reg      <= diag_reg[k_next];
                            out_last_reg <= (k_next == IW'(N - 1));
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == STREAM);
    assign bus.out       = out_reg;
    assign bus.out_index = k_reg;
    assign bus.out_last  = out_last_reg;

`ifdef FROM_DIAGONAL_STREAM_CHECK_EN
    genvar gj;
    logic [ROWS*COLS-1:0] offdiag_nz;
    logic                 is_diag_next;
    logic                 is_diag_reg;

    // One flag per element: set when an off-diagonal element is non-zero.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                if (gi != gj) begin : g_off
                    assign offdiag_nz[gi*COLS + gj] = |bus.in[gi][gj];
                end else begin : g_on
                    assign offdiag_nz[gi*COLS + gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign is_diag_next = ~|offdiag_nz;

    // Verdict is taken at acceptance and held until the next matrix or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_diag_reg <= 1'b0;
        end else if (accept) begin
            is_diag_reg <= is_diag_next;
        end
    end

    assign bus.is_diagonal = is_diag_reg;
`else
    assign bus.is_diagonal = 1'b0;
`endif

endmodule
